// File: rtl/rsa_operand_loader_pkg.sv
// Shared RSA definitions used by the operand loader and the MonPro datapath:
// operand geometry and the loader FSM state encoding.
package rsa_operand_loader_pkg;

    // Operand word width in bits.
    localparam int RSA_DATA_WIDTH = 64;
    // Word-address width; an operand is 2**RSA_ADDR_WIDTH words long.
    localparam int RSA_ADDR_WIDTH = 6;
    // Words per operand (64 x 64 = 4096-bit operands).
    localparam int RSA_TOTAL_ADDR = 2 ** RSA_ADDR_WIDTH;

    // Loader FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2
    } loader_state_e;

endpackage

// File: rtl/rsa_word_ram.sv
// Single-port-write, registered-read word buffer holding one operand.
// The storage array is never reset; only the read register is.
module rsa_word_ram #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 6,
    parameter int DEPTH      = 64
)(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Write port: store the word when the loader accepts it.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read port: one-cycle registered read; a same-cycle write is seen next read.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/rsa_operand_loader.sv
// Collects one RSA operand set (ciphertext m, exponent e, modulus n) word by
// word, least significant word first, into three word buffers, tracks the
// exponent's most significant nonzero word and the modulus parity, and then
// raises operands_ready as the start request to MonPro until op_done.
//
// Handshake: a word transfers on every rising edge where in_valid and
// in_ready are both 1; in_ready is 1 only while loading and not restarting,
// and it never depends on in_valid.
module rsa_operand_loader
    import rsa_operand_loader_pkg::*;
#(
    parameter int DATA_WIDTH = RSA_DATA_WIDTH,
    parameter int ADDR_WIDTH = RSA_ADDR_WIDTH,
    parameter int TOTAL_ADDR = 2 ** ADDR_WIDTH
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] m_in,
    input  logic [DATA_WIDTH-1:0] e_in,
    input  logic [DATA_WIDTH-1:0] n_in,
    output logic                  operands_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_m,
    output logic [DATA_WIDTH-1:0] rd_e,
    output logic [DATA_WIDTH-1:0] rd_n,
    input  logic                  op_done,
    output logic [ADDR_WIDTH-1:0] e_msw_idx,
    output logic                  e_zero,
    output logic                  n_even_err,
    output loader_state_e         dbg_state
);

    localparam logic [ADDR_WIDTH-1:0] C_LAST_ADDR = ADDR_WIDTH'(TOTAL_ADDR - 1);

    loader_state_e         r_state;
    loader_state_e         w_next_state;
    logic                  w_in_ready;
    logic                  w_accept;
    logic                  w_restart;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] w_cnt_next;
    logic [ADDR_WIDTH-1:0] r_e_msw_idx;
    logic                  r_e_zero;
    logic                  r_n_even_err;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state, handshake and restart decode.
    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        w_accept     = 1'b0;
        w_restart    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (load_start) begin
                    w_next_state = ST_LOAD;
                    w_restart    = 1'b1;
                end
            end
            ST_LOAD: begin
                if (load_start) begin
                    // Restart takes priority; no word is taken this cycle.
                    w_restart = 1'b1;
                end else begin
                    w_in_ready = 1'b1;
                    if (in_valid) begin
                        w_accept = 1'b1;
                        if (r_cnt == C_LAST_ADDR) begin
                            w_next_state = ST_READY;
                        end
                    end
                end
            end
            ST_READY: begin
                if (op_done) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Word counter wraps after the last word of an operand.
    assign w_cnt_next = (r_cnt == C_LAST_ADDR) ? '0 : r_cnt + 1'b1;

    // Word counter and operand flags; flags hold their value outside LOAD.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt        <= '0;
            r_e_msw_idx  <= '0;
            r_e_zero     <= 1'b1;
            r_n_even_err <= 1'b0;
        end else if (w_restart) begin
            r_cnt        <= '0;
            r_e_msw_idx  <= '0;
            r_e_zero     <= 1'b1;
            r_n_even_err <= 1'b0;
        end else if (w_accept) begin
            r_cnt <= w_cnt_next;
            if (|e_in) begin
                r_e_msw_idx <= r_cnt;
                r_e_zero    <= 1'b0;
            end
            if (r_cnt == '0) begin
                r_n_even_err <= ~n_in[0];
            end
        end
    end

    rsa_word_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (TOTAL_ADDR)
    ) u_m_ram (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_we    (w_accept),
        .i_waddr (r_cnt),
        .i_wdata (m_in),
        .i_raddr (rd_addr),
        .o_rdata (rd_m)
    );

    rsa_word_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (TOTAL_ADDR)
    ) u_e_ram (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_we    (w_accept),
        .i_waddr (r_cnt),
        .i_wdata (e_in),
        .i_raddr (rd_addr),
        .o_rdata (rd_e)
    );

    rsa_word_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (TOTAL_ADDR)
    ) u_n_ram (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_we    (w_accept),
        .i_waddr (r_cnt),
        .i_wdata (n_in),
        .i_raddr (rd_addr),
        .o_rdata (rd_n)
    );

    assign in_ready       = w_in_ready;
    assign operands_ready = (r_state == ST_READY);
    assign e_msw_idx      = r_e_msw_idx;
    assign e_zero         = r_e_zero;
    assign n_even_err     = r_n_even_err;
    assign dbg_state      = r_state;

endmodule

// File: tb/tb_rsa_operand_loader.sv
// Bench for rsa_operand_loader: randomized operand sets driven through the
// word handshake, a behavioural model of the operand buffers and flags, a
// per-cycle compare process, and literal checks on the documented cases.
module tb_rsa_operand_loader;
    import rsa_operand_loader_pkg::*;

    localparam int DW = 64;
    localparam int AW = 6;
    localparam int TA = 64;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic          load_start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] m_in = '0;
    logic [DW-1:0] e_in = '0;
    logic [DW-1:0] n_in = '0;
    logic          operands_ready;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_m;
    logic [DW-1:0] rd_e;
    logic [DW-1:0] rd_n;
    logic          op_done = 1'b0;
    logic [AW-1:0] e_msw_idx;
    logic          e_zero;
    logic          n_even_err;
    loader_state_e dbg_state;

    rsa_operand_loader dut (
        .clk            (clk),
        .reset          (reset),
        .load_start     (load_start),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .m_in           (m_in),
        .e_in           (e_in),
        .n_in           (n_in),
        .operands_ready (operands_ready),
        .rd_addr        (rd_addr),
        .rd_m           (rd_m),
        .rd_e           (rd_e),
        .rd_n           (rd_n),
        .op_done        (op_done),
        .e_msw_idx      (e_msw_idx),
        .e_zero         (e_zero),
        .n_even_err     (n_even_err),
        .dbg_state      (dbg_state)
    );

    // ---------------- scoreboard counters ----------------
    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Buffer contents, which addresses hold known data, the phase of the
    // operand set, and how many words of the current set have arrived.
    logic [DW-1:0] mm [TA];
    logic [DW-1:0] me [TA];
    logic [DW-1:0] mn [TA];
    bit            wr [TA];
    loader_state_e ph = ST_IDLE;
    int            set_cnt = 0;
    logic [DW-1:0] exp_rd_m = '0;
    logic [DW-1:0] exp_rd_e = '0;
    logic [DW-1:0] exp_rd_n = '0;
    bit            rd_known = 1'b1;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            ph       = ST_IDLE;
            set_cnt  = 0;
            exp_rd_m = '0;
            exp_rd_e = '0;
            exp_rd_n = '0;
            rd_known = 1'b1;
        end else begin
            rd_known = wr[rd_addr];
            exp_rd_m = mm[rd_addr];
            exp_rd_e = me[rd_addr];
            exp_rd_n = mn[rd_addr];
            case (ph)
                ST_IDLE: if (load_start) begin
                    ph      = ST_LOAD;
                    set_cnt = 0;
                end
                ST_LOAD: begin
                    if (load_start) begin
                        set_cnt = 0;
                    end else if (in_valid) begin
                        mm[set_cnt] = m_in;
                        me[set_cnt] = e_in;
                        mn[set_cnt] = n_in;
                        wr[set_cnt] = 1'b1;
                        set_cnt++;
                        if (set_cnt == TA) ph = ST_READY;
                    end
                end
                ST_READY: if (op_done) ph = ST_IDLE;
                default: ph = ST_IDLE;
            endcase
        end
    end

    // Per-cycle comparison against the model, sampled on the falling edge.
    always @(negedge clk) begin
        int  exp_idx;
        bit  exp_zero;
        bit  exp_nerr;
        exp_idx  = 0;
        exp_zero = 1'b1;
        for (int i = 0; i < set_cnt; i++) begin
            if (me[i] != '0) begin
                exp_idx  = i;
                exp_zero = 1'b0;
            end
        end
        exp_nerr = (set_cnt > 0) && (mn[0][0] == 1'b0);
        chk("in_ready", DW'(in_ready), DW'(ph == ST_LOAD && !load_start));
        chk("operands_ready", DW'(operands_ready), DW'(ph == ST_READY));
        chk("state", DW'(dbg_state), DW'(ph));
        chk("e_msw_idx", DW'(e_msw_idx), DW'(exp_idx));
        chk("e_zero", DW'(e_zero), DW'(exp_zero));
        chk("n_even_err", DW'(n_even_err), DW'(exp_nerr));
        if (rd_known) begin
            chk("rd_m", rd_m, exp_rd_m);
            chk("rd_e", rd_e, exp_rd_e);
            chk("rd_n", rd_n, exp_rd_n);
        end
    end

    // ---------------- driver tasks ----------------
    logic [DW-1:0] tm [TA];
    logic [DW-1:0] te [TA];
    logic [DW-1:0] tn [TA];

    function automatic logic [DW-1:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        load_start = 1'b0;
        in_valid   = 1'b0;
        op_done    = 1'b0;
        m_in       = rnd64();
        e_in       = rnd64();
        n_in       = rnd64();
        rd_addr    = AW'($urandom_range(0, TA - 1));
    endtask

    task automatic pulse_start();
        idle_inputs();
        load_start = 1'b1;
        in_valid   = 1'($urandom_range(0, 1));
        tick();
        load_start = 1'b0;
        in_valid   = 1'b0;
    endtask

    task automatic send_word(input logic [DW-1:0] m, input logic [DW-1:0] e,
                             input logic [DW-1:0] n, input int gap);
        repeat (gap) begin
            idle_inputs();
            op_done = 1'($urandom_range(0, 1));
            tick();
        end
        idle_inputs();
        op_done  = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
        m_in     = m;
        e_in     = e;
        n_in     = n;
        tick();
        idle_inputs();
    endtask

    task automatic send_range(input int first, input int last, input int gmin, input int gmax);
        for (int i = first; i <= last; i++) begin
            send_word(tm[i], te[i], tn[i], $urandom_range(gmin, gmax));
        end
    endtask

    task automatic fill_random(input int e_density);
        for (int i = 0; i < TA; i++) begin
            tm[i] = rnd64();
            tn[i] = rnd64();
            te[i] = ($urandom_range(0, 7) < e_density) ? (rnd64() | 64'h1) : '0;
        end
    endtask

    task automatic finish_op();
        idle_inputs();
        op_done = 1'b1;
        tick();
        idle_inputs();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset values while reset is held, with noise on the inputs.
        idle_inputs();
        in_valid = 1'b1;
        repeat (3) tick();
        chk("rst in_ready", DW'(in_ready), '0);
        chk("rst operands_ready", DW'(operands_ready), '0);
        chk("rst e_msw_idx", DW'(e_msw_idx), '0);
        chk("rst e_zero", DW'(e_zero), DW'(1));
        chk("rst n_even_err", DW'(n_even_err), '0);
        chk("rst rd_m", rd_m, '0);
        reset = 1'b1;
        idle_inputs();
        in_valid = 1'b1;
        tick();
        idle_inputs();

        // Set A: only e word 0 nonzero, odd modulus.
        fill_random(0);
        tm[0] = 64'h95d1805142cb6d1d;
        te[0] = 64'h5;
        tn[0] = 64'h1622bd795fec898f;
        pulse_start();
        send_range(0, TA - 1, 0, 0);
        chk("A operands_ready", DW'(operands_ready), DW'(1));
        chk("A e_msw_idx", DW'(e_msw_idx), '0);
        chk("A e_zero", DW'(e_zero), '0);
        chk("A n_even_err", DW'(n_even_err), '0);
        pulse_start();
        chk("A start ignored", DW'(operands_ready), DW'(1));
        idle_inputs();
        in_valid = 1'b1;
        rd_addr = '0;
        tick();
        chk("A rd_m[0]", rd_m, 64'h95d1805142cb6d1d);
        idle_inputs();
        rd_addr = AW'(TA - 1);
        tick();
        chk("A rd_n[63]", rd_n, tn[TA - 1]);
        finish_op();
        chk("A op_done", DW'(operands_ready), '0);

        // Set B: all-zero exponent, even modulus.
        fill_random(0);
        tn[0] = 64'ha9ec0806705fca16;
        pulse_start();
        send_range(0, TA - 1, 0, 1);
        chk("B n_even_err", DW'(n_even_err), DW'(1));
        chk("B e_zero", DW'(e_zero), DW'(1));
        chk("B e_msw_idx", DW'(e_msw_idx), '0);
        finish_op();

        // Set C: e nonzero only at words 3 and 40, gaps of 1-5 cycles.
        fill_random(0);
        te[3]  = rnd64() | 64'h1;
        te[40] = rnd64() | 64'h1;
        pulse_start();
        send_range(0, TA - 1, 1, 5);
        chk("C e_msw_idx", DW'(e_msw_idx), DW'(40));
        chk("C e_zero", DW'(e_zero), '0);
        for (int a = 0; a < TA; a++) begin
            idle_inputs();
            rd_addr = AW'(a);
            tick();
            chk("C rd_m", rd_m, tm[a]);
            chk("C rd_e", rd_e, te[a]);
            chk("C rd_n", rd_n, tn[a]);
        end
        finish_op();

        // Set D: restart after 20 words, then a full 64-word set.
        fill_random(2);
        pulse_start();
        send_range(0, 19, 0, 2);
        pulse_start();
        fill_random(2);
        send_range(0, TA - 2, 0, 1);
        chk("D not ready at 63", DW'(operands_ready), '0);
        send_range(TA - 1, TA - 1, 0, 1);
        chk("D ready at 64", DW'(operands_ready), DW'(1));
        repeat (4) begin
            idle_inputs();
            in_valid = 1'b1;
            tick();
        end
        finish_op();
        chk("D idle after op_done", DW'(dbg_state), DW'(ST_IDLE));
        idle_inputs();
        rd_addr = AW'(5);
        tick();
        chk("D retained rd_m[5]", rd_m, tm[5]);

        // Set E: reset in the middle of a load.
        fill_random(3);
        pulse_start();
        send_range(0, 29, 0, 1);
        reset = 1'b0;
        #1;
        chk("E rst operands_ready", DW'(operands_ready), '0);
        chk("E rst in_ready", DW'(in_ready), '0);
        chk("E rst e_zero", DW'(e_zero), DW'(1));
        chk("E rst e_msw_idx", DW'(e_msw_idx), '0);
        chk("E rst n_even_err", DW'(n_even_err), '0);
        chk("E rst rd_e", rd_e, '0);
        chk("E rst state", DW'(dbg_state), DW'(ST_IDLE));
        tick();
        reset = 1'b1;
        finish_op();
        chk("E op_done in idle", DW'(dbg_state), DW'(ST_IDLE));

        // Random sets with random gaps and stray control inputs.
        for (int k = 0; k < 3; k++) begin
            fill_random(k + 1);
            pulse_start();
            send_range(0, TA - 1, 0, 3);
            repeat (8) begin
                idle_inputs();
                in_valid   = 1'($urandom_range(0, 1));
                load_start = 1'($urandom_range(0, 1));
                tick();
            end
            finish_op();
        end
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rsa_operand_loader.md
RSA_OPERAND_LOADER -- requirements
Module: rsa_operand_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 64: operand word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 6: word-address width.
REQ-003 Parameter TOTAL_ADDR, default 2**ADDR_WIDTH (64): words per operand, i.e. 4096-bit operands.
REQ-004 Port clk, input, 1: sole clock; all state is updated on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-low reset.
REQ-006 Port load_start, input, 1: pulse that begins a new operand set.
REQ-007 Port in_valid, input, 1: the m_in, e_in and n_in words are valid.
REQ-008 Port in_ready, output, 1: loader accepts a word this cycle.
REQ-009 Port m_in, input, DATA_WIDTH: ciphertext word.
REQ-010 Port e_in, input, DATA_WIDTH: private-exponent word.
REQ-011 Port n_in, input, DATA_WIDTH: modulus word.
REQ-012 Port operands_ready, output, 1: a full operand set is stored; this is the start request to the downstream MonPro.
REQ-013 Port rd_addr, input, ADDR_WIDTH: word read address from MonPro.
REQ-014 Port rd_m, output, DATA_WIDTH: registered m word at rd_addr.
REQ-015 Port rd_e, output, DATA_WIDTH: registered e word at rd_addr.
REQ-016 Port rd_n, output, DATA_WIDTH: registered n word at rd_addr.
REQ-017 Port op_done, input, 1: MonPro has finished and releases the buffers.
REQ-018 Port e_msw_idx, output, ADDR_WIDTH: index of the highest nonzero e word.
REQ-019 Port e_zero, output, 1: every e word is zero.
REQ-020 Port n_even_err, output, 1: n word 0 is even (Montgomery requires odd n).

Function
REQ-021 The FSM SHALL have states IDLE, LOAD and READY.
REQ-022 IDLE SHALL go to LOAD on load_start, clearing the word counter, e_msw_idx and n_even_err and setting e_zero to 1.
REQ-023 in_ready SHALL be 1 only in LOAD; a word SHALL be accepted on each cycle with in_valid=1 and in_ready=1.
REQ-024 Accepted words SHALL be written to address = word counter; word 0 is the least significant and arrives first.
REQ-025 On each accepted word with e_in nonzero, e_msw_idx SHALL take the counter value and e_zero SHALL clear.
REQ-026 On accepted word 0, n_even_err SHALL take the inverse of n_in[0].
REQ-027 The counter SHALL wrap from TOTAL_ADDR-1 to 0; accepting word TOTAL_ADDR-1 SHALL move the FSM to READY on the next edge.
REQ-028 operands_ready SHALL be 1 throughout READY and 0 otherwise.
REQ-029 rd_m, rd_e and rd_n SHALL present the word at rd_addr one cycle after rd_addr is applied, in every state.
REQ-030 READY SHALL go to IDLE on op_done; buffer contents SHALL be retained.
REQ-031 load_start in LOAD SHALL restart the load: counter 0, flags re-initialised, no word accepted that cycle.
REQ-032 load_start in READY SHALL be ignored.
REQ-033 op_done outside READY SHALL be ignored.
REQ-034 in_valid in IDLE or READY SHALL have no effect.

Reset
REQ-035 While reset=0, the FSM SHALL be IDLE, the counter 0, in_ready 0, operands_ready 0, e_msw_idx 0, e_zero 1, n_even_err 0, and rd_m/rd_e/rd_n 0.
REQ-036 Reset during LOAD SHALL abandon the partial set; buffer RAM contents are not reset.

Structure
REQ-037 DATA_WIDTH, ADDR_WIDTH, TOTAL_ADDR and the FSM state encodings SHALL reside in the shared RSA package/defines used with MonPro.
REQ-038 The three buffers SHALL each be an instance of one sub-module, rsa_word_ram (1 write port, 1 registered read port, TOTAL_ADDR x DATA_WIDTH).

Verification
REQ-039 Load 64 words, word 0 with e=64'h5, n=64'h1622bd795fec898f and all other e words 0 -> operands_ready=1 after word 63; e_msw_idx=0, e_zero=0, n_even_err=0.
REQ-040 In READY, rd_addr=0 -> next cycle rd_m=64'h95d1805142cb6d1d; rd_addr=63 -> rd_n = the 64th n word.
REQ-041 Load word 0 with n=64'ha9ec0806705fca16 -> n_even_err=1; all e words zero -> e_zero=1, e_msw_idx=0.
REQ-042 Nonzero e only at words 3 and 40 -> e_msw_idx=40; apply in_valid gaps of 1–5 cycles -> identical stored data.
REQ-043 load_start after 20 words -> counter restarts; 64 further words are needed before operands_ready; load_start in READY -> no change.
REQ-044 Reset asserted at word 30 -> all outputs at reset values immediately; op_done in READY -> IDLE, and stored data remains readable.
